// File: rtl/tick_monitor_if.sv
// tick_monitor_if: tick stream input and measurement/status outputs of tick_monitor.
//   master: drives clk_en_in, observes results (testbench / system side)
//   slave : consumes clk_en_in, drives period, period_valid, locked, err_pulse,
//           timeout, err_count, min_period, max_period (monitor side)
interface tick_monitor_if #(parameter int CNT_W = 16);
  logic             clk_en_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err_pulse;
  logic             timeout;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
  modport master (
    output clk_en_in,
    input  period, period_valid, locked, err_pulse, timeout, err_count, min_period, max_period
  );
  modport slave (
    input  clk_en_in,
    output period, period_valid, locked, err_pulse, timeout, err_count, min_period, max_period
  );
endinterface

// File: rtl/tick_monitor.sv
// tick_monitor: measures tick-to-tick period of an enable stream, locks onto EXP_PERIOD, flags loss.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): clk_en_in in; period/period_valid, locked, err_pulse, timeout,
//                err_count, min_period/max_period out
//   Optional macro TICK_MONITOR_MINMAX_EN builds min/max period tracking;
//   otherwise min_period/max_period are tied to 0.
module tick_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 20
) (
  input  logic           clk,
  input  logic           reset,
  tick_monitor_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam int MW = $clog2(LOCK_CNT + 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d, period_q, period_d;
  logic [MW-1:0]    match_q, match_d;
  logic [7:0]       errc_q, errc_d;
  logic             pv_q, pv_d, err_q, to_q, to_d, locked_q, lose;
  logic [CNT_W:0]   meas, diff;
  logic             tick, in_tol, to_hit;
  assign tick   = bus.clk_en_in;
  // One extra bit keeps gap+1 and the deviation free of wrap-around.
  assign meas   = {1'b0, gap_q} + (CNT_W+1)'(1);
  assign diff   = (meas >= (CNT_W+1)'(EXP_PERIOD)) ? meas - (CNT_W+1)'(EXP_PERIOD)
                                                   : (CNT_W+1)'(EXP_PERIOD) - meas;
  assign in_tol = diff <= (CNT_W+1)'(TOL);
  // A tick in the timeout cycle wins, so to_hit requires no tick.
  assign to_hit = (state_q != IDLE) && !tick && (gap_q == CNT_W'(TIMEOUT - 1));
  always_comb begin
    state_d  = state_q;
    gap_d    = tick ? '0 : (&gap_q ? gap_q : gap_q + 1'b1);
    match_d  = match_q;
    period_d = period_q;
    pv_d     = 1'b0;
    to_d     = 1'b0;
    lose     = 1'b0;
    if (to_hit) begin
      state_d = IDLE;
      gap_d   = '0;
      to_d    = 1'b1;
      lose    = state_q == LOCKED;
    end else if (tick) begin
      if (state_q == IDLE) begin
        state_d = ACQUIRE;
        match_d = '0;
      end else begin
        pv_d     = 1'b1;
        period_d = meas[CNT_W] ? '1 : meas[CNT_W-1:0];
        if (state_q == ACQUIRE) begin
          match_d = in_tol ? match_q + 1'b1 : '0;
          state_d = (in_tol && match_q == MW'(LOCK_CNT - 1)) ? LOCKED : ACQUIRE;
        end else if (!in_tol) begin
          lose    = 1'b1;
          state_d = ACQUIRE;
          match_d = '0;
        end
      end
    end
    errc_d = (lose && errc_q != 8'hff) ? errc_q + 1'b1 : errc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      match_q  <= match_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      err_q    <= lose;
      to_q     <= to_d;
      locked_q <= state_d == LOCKED;
      errc_q   <= errc_d;
    end
  end
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.err_pulse    = err_q;
  assign bus.timeout      = to_q;
  assign bus.err_count    = errc_q;
`ifdef TICK_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else if (pv_d) begin
      if (period_d < min_q) min_q <= period_d;
      if (period_d > max_q) max_q <= period_d;
    end
  end
  assign bus.min_period = min_q;
  assign bus.max_period = max_q;
`else
  assign bus.min_period = '0;
  assign bus.max_period = '0;
`endif
endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of the gap counter and period outputs.
REQ-002 Parameter EXP_PERIOD, default 10, expected clocks between enable ticks.
REQ-003 Parameter TOL, default 0, allowed deviation in clocks from EXP_PERIOD.
REQ-004 Parameter LOCK_CNT, default 4, consecutive in-tolerance periods required to lock.
REQ-005 Parameter TIMEOUT, default 20, clocks without a tick that declare loss of the tick stream.
REQ-006 clk  input  1  system clock; all logic on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 clk_en_in  input  1  enable tick stream under test, one cycle high per tick.
REQ-009 period  output  CNT_W  last measured tick-to-tick period in clocks.
REQ-010 period_valid  output  1  one-cycle pulse when period updates.
REQ-011 locked  output  1  high while the state machine is in LOCKED.
REQ-012 err_pulse  output  1  one-cycle pulse on a lock-loss event.
REQ-013 timeout  output  1  one-cycle pulse when TIMEOUT clocks pass without a tick.
REQ-014 err_count  output  8  saturating count of lock-loss events.
REQ-015 min_period, max_period  output  CNT_W each  extreme periods measured (see Configuration).

Function
REQ-016 Gap counter gap: cleared on a tick cycle, else incremented, saturating at all-ones.
REQ-017 Measured period on a tick cycle = gap+1; ticks every 10 clocks measure 10.
REQ-018 All outputs registered; period, period_valid, err_pulse and timeout appear the cycle after the causing tick or timeout.
REQ-019 States: IDLE (no reference tick), ACQUIRE (counting matches), LOCKED.
REQ-020 IDLE: a tick starts the reference -> ACQUIRE with match=0; no period_valid for that tick.
REQ-021 ACQUIRE/LOCKED: every tick produces a measurement with a period_valid pulse.
REQ-022 In tolerance means |measured - EXP_PERIOD| <= TOL, computed at CNT_W+1 bits with no wrap.
REQ-023 ACQUIRE, in tolerance: match increments; match reaching LOCK_CNT -> LOCKED.
REQ-024 ACQUIRE, out of tolerance: match cleared, stays ACQUIRE, no err_pulse.
REQ-025 LOCKED, out of tolerance: err_pulse, err_count+1 saturating at 255, -> ACQUIRE with match=0.
REQ-026 No tick while gap == TIMEOUT-1 (any non-IDLE state): timeout pulse -> IDLE, gap cleared.
REQ-027 A timeout from LOCKED also pulses err_pulse and increments err_count.
REQ-028 Tick and timeout condition in the same cycle: the tick wins, is measured normally, no timeout.
REQ-029 IDLE never raises timeout; gap only saturates.
REQ-030 locked is low in IDLE and ACQUIRE.

Reset
REQ-031 Reset clears state to IDLE and clears gap, match, period, period_valid, locked, err_pulse, timeout and err_count.
REQ-032 Reset sets min_period to all-ones and max_period to 0.
REQ-033 Reset mid-measurement discards the partial gap; the first tick after reset is a reference only.
REQ-034 Reset dominates clk_en_in in the same cycle.

Configuration
REQ-035 With macro TICK_MONITOR_MINMAX_EN defined, every measurement updates min_period and max_period where it is a new extreme.
REQ-036 Without TICK_MONITOR_MINMAX_EN, the min/max registers are not built and both ports are driven constant 0.

Verification
REQ-037 Defaults; ticks every 10 clocks -> first measurement period=10; locked rises one cycle after the 4th valid measurement.
REQ-038 Locked; one gap of 12 clocks -> period=12, err_pulse once, err_count=1, locked drops, relocks after 4 periods of 10.
REQ-039 Locked; ticks stop -> timeout pulse 20 clocks after the last tick, err_count+1, state IDLE, no period_valid.
REQ-040 Tick exactly 20 clocks after the previous one -> period=20, timeout stays low.
REQ-041 Reset asserted with clk_en_in high while locked -> all outputs 0 next cycle; the following tick gives no period_valid.
REQ-042 Macro defined; periods 10, 8, 13 -> min_period=8, max_period=13; macro undefined -> both 0.
